bus_arbiter12: RTL and testbench



---
 rtl/bus_arbiter12.sv | 78 +++++++
 tb/tb_bus_arbiter12.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter12.sv
// bus_arbiter12: round-robin arbiter and mux-select sequencer for 12 requesters with a per-grant hold limit
module bus_arbiter12 #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] req,
  input  logic        done,
  output logic [11:0] gnt,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic [11:0] gnt_q, gnt_d;
  logic [3:0]  sel_q, sel_d;
  logic        timeout_q, timeout_d;
  logic        lim, own_req, rel;
  logic [3:0]  nxt_ptr, base;
  logic [4:0]  pk;
  function automatic logic [4:0] pick(input logic [11:0] r, input logic [3:0] p);
    logic [4:0] res;
    logic [4:0] s;
    res = '0;
    for (int i = 11; i >= 0; i--) begin
      s = {1'b0, p} + 5'(i);
      s = (s >= 5'd12) ? s - 5'd12 : s;
      if (r[s[3:0]]) res = {1'b1, s[3:0]};
    end
    return res;
  endfunction
  always_comb begin
    lim       = hold_q == 8'(MAX_HOLD - 1);
    own_req   = |(req & gnt_q);
    rel       = (state_q == BUSY) && (done || !own_req || lim);
    nxt_ptr   = (sel_q == 4'd11) ? 4'd0 : sel_q + 4'd1;
    base      = rel ? nxt_ptr : ptr_q;
    pk        = pick(req, base);
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    hold_d    = (state_q == BUSY) ? hold_q + 8'd1 : 8'd0;
    if (state_q == IDLE ? pk[4] : rel) begin
      ptr_d     = (state_q == BUSY) ? nxt_ptr : ptr_q;
      timeout_d = (state_q == BUSY) && lim && !done && own_req;
      state_d   = pk[4] ? BUSY : IDLE;
      gnt_d     = pk[4] ? 12'b1 << pk[3:0] : 12'h000;
      sel_d     = pk[4] ? pk[3:0] : 4'hF;
      hold_d    = 8'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 4'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 12'h000;
      sel_q     <= 4'hF;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = state_q == BUSY;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_bus_arbiter12.sv
// tb_bus_arbiter12: randomized and directed checks of bus_arbiter12 against a cycle-level reference model
module tb_bus_arbiter12;
  localparam int MH = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] req = '0;
  logic        done = 1'b0;
  logic [11:0] gnt;
  logic [3:0]  sel;
  logic        busy;
  logic        timeout;
  int checks = 0;
  int passes = 0;
  int m_ptr, m_own, m_held;
  logic m_to;
  bus_arbiter12 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic int first_req(input logic [11:0] r, input int p);
    for (int i = 0; i < 12; i++) if (r[(p + i) % 12]) return (p + i) % 12;
    return -1;
  endfunction
  function automatic logic [11:0] m_gnt();
    return (m_own < 0) ? 12'h000 : 12'h001 << m_own;
  endfunction
  function automatic logic [3:0] m_sel();
    return (m_own < 0) ? 4'hF : 4'(m_own);
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_own = -1; m_held = 0; m_to = 1'b0;
  endtask
  task automatic tick();
    bit forced, own_r;
    @(posedge clk);
    m_to = 1'b0;
    if (m_own < 0) begin
      m_own = first_req(req, m_ptr);
      m_held = 1;
    end else begin
      forced = (m_held == MH);
      own_r = req[m_own];
      if (done || !own_r || forced) begin
        m_to = forced && !done && own_r;
        m_ptr = (m_own + 1) % 12;
        m_own = first_req(req, m_ptr);
        m_held = 1;
      end else m_held++;
    end
    #1;
  endtask
  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (gnt !== 12'h000 || sel !== 4'hF || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset_vals gnt=%h sel=%h busy=%b to=%b expected 000 f 0 0", gnt, sel, busy, timeout);
    else passes++;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt !== 12'h000 || sel !== 4'hF || busy !== 1'b0)
        $display("FAIL idle_no_req cyc%0d gnt=%h sel=%h busy=%b expected 000 f 0", i, gnt, sel, busy);
      else passes++;
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] order[$];
    logic [3:0] exp_order[4] = '{4'd0, 4'd4, 4'd0, 4'd4};
    logic [3:0] prev = 4'hF;
    int gaps = 0;
    int cyc = 0;
    req = 12'h011;
    while (order.size() < 4 && cyc < 40) begin
      tick();
      cyc++;
      checks++;
      if (gnt !== m_gnt() || sel !== m_sel() || busy !== (m_own >= 0) || timeout !== m_to)
        $display("FAIL rr_model gnt=%h sel=%h to=%b expected %h %h %b", gnt, sel, timeout, m_gnt(), m_sel(), m_to);
      else passes++;
      if (busy && sel != prev) order.push_back(sel);
      if (!busy && order.size() > 0) gaps++;
      prev = busy ? sel : 4'hF;
      done = (m_own >= 0) && (m_held == 2);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= order.size() || order[i] !== exp_order[i])
        $display("FAIL rr_order idx%0d got=%h expected %h", i, (i < order.size()) ? order[i] : 4'hX, exp_order[i]);
      else passes++;
    end
    checks++;
    if (gaps != 0) $display("FAIL rr_gap idle_cycles=%0d expected 0", gaps);
    else passes++;
    req = 12'h000; done = 1'b0;
    tick();
  endtask
  task automatic test_wrap();
    req = 12'h800;
    tick();
    checks++;
    if (sel !== 4'hB || gnt !== 12'h800 || sel !== m_sel())
      $display("FAIL wrap_first sel=%h gnt=%h expected b 800", sel, gnt);
    else passes++;
    tick();
    req = 12'h801; done = 1'b1;
    tick();
    checks++;
    if (sel !== 4'h0 || gnt !== 12'h001 || sel !== m_sel())
      $display("FAIL wrap_to_zero sel=%h gnt=%h expected 0 001", sel, gnt);
    else passes++;
    req = 12'h000; done = 1'b0;
    tick();
  endtask
  task automatic test_timeout();
    int pulses = 0;
    req = 12'h004;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (gnt !== 12'h004 || timeout !== m_to || sel !== 4'd2)
        $display("FAIL hold_limit cyc%0d gnt=%h sel=%h to=%b expected 004 2 %b", i, gnt, sel, timeout, m_to);
      else passes++;
      pulses += int'(timeout);
    end
    checks++;
    if (pulses != 3) $display("FAIL timeout_count got=%0d expected 3", pulses);
    else passes++;
    req = 12'h000;
    tick();
  endtask
  task automatic test_done_at_limit();
    req = 12'h004;
    tick();
    req = 12'h084;
    repeat (3) tick();
    done = 1'b1;
    tick();
    checks++;
    if (sel !== 4'd7 || gnt !== 12'h080 || timeout !== 1'b0 || m_to !== 1'b0)
      $display("FAIL done_at_limit sel=%h gnt=%h to=%b expected 7 080 0", sel, gnt, timeout);
    else passes++;
    done = 1'b0; req = 12'h000;
    tick();
  endtask
  task automatic test_async_reset();
    req = 12'h020;
    tick();
    checks++;
    if (gnt !== 12'h020 || sel !== 4'd5) $display("FAIL pre_reset_grant gnt=%h sel=%h expected 020 5", gnt, sel);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 12'h000 || sel !== 4'hF || busy !== 1'b0 || timeout !== 1'b0)
      $display("FAIL async_reset gnt=%h sel=%h busy=%b expected 000 f 0", gnt, sel, busy);
    else passes++;
    model_reset();
    req = 12'h021;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 12'h001 || sel !== 4'd0) $display("FAIL post_reset_grant gnt=%h sel=%h expected 001 0", gnt, sel);
    else passes++;
    req = 12'h000;
    tick();
  endtask
  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) req = 12'($urandom) & 12'($urandom);
      done = ($urandom_range(3) == 0);
      tick();
      checks++;
      if (gnt !== m_gnt() || sel !== m_sel() || busy !== (m_own >= 0) || timeout !== m_to) begin
        if (errs < 10)
          $display("FAIL random cyc%0d req=%h gnt=%h sel=%h busy=%b to=%b expected %h %h %b %b",
                   i, req, gnt, sel, busy, timeout, m_gnt(), m_sel(), m_own >= 0, m_to);
        errs++;
      end else passes++;
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_done_at_limit();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
